// File: rtl/mux_n_reg.sv
// mux_n_reg: parametrised N-to-1 multiplexer with a registered output stage and a
// one-entry skid buffer, valid/ready handshaked on both sides.
//
// Parameters:
//   WIDTH  data width of each input and of the output
//   N      number of inputs (2..16)
//   SEL_W  select width, N <= 2**SEL_W
//
// Ports:
//   clk        input   rising-edge clock
//   reset_n    input   asynchronous active-low reset
//   in_data    input   packed inputs, input k at [k*WIDTH +: WIDTH]
//   sel        input   input index, sampled on accept
//   in_valid   input   source offers a beat
//   in_ready   output  block can accept a beat (registered, = !skid_full)
//   out_data   output  registered selected data
//   out_valid  output  out_data holds a beat
//   out_ready  input   consumer takes the beat
//   sel_err    output  one-cycle pulse after an accepted beat with sel >= N
//
// Optional feature, enabled by defining MUX_N_REG_ERRCNT_EN:
//   err_count  output  saturating count (0..255) of invalid-select accepts
//   err_clr    input   clears err_count next cycle, wins over an increment

module mux_n_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 3,
    parameter int unsigned SEL_W = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
`ifdef MUX_N_REG_ERRCNT_EN
    ,
    output logic [7:0]         err_count,
    input  logic               err_clr
`endif
);

    // Encoding is {skid_full, out_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b11
    } state_e;

    // N may equal 2**SEL_W, so compare with one extra bit.
    localparam logic [SEL_W:0] NumIn = (SEL_W + 1)'(N);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] sel_data;
    logic             sel_ok;
    logic             accept;
    logic             acc_ok;
    logic             acc_bad;
    logic             drain;

    // Select decode. Out-of-range selects yield zero but are never loaded.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_ok    = ({1'b0, sel} < NumIn);
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign out_data  = out_data_q;
    assign sel_err   = sel_err_q;

    assign accept  = in_valid & in_ready;
    assign acc_ok  = accept & sel_ok;
    assign acc_bad = accept & ~sel_ok;
    assign drain   = out_valid & out_ready;

    // Next-state and datapath load control.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        sel_err_d   = acc_bad;

        unique case (state_q)
            StEmpty: begin
                if (acc_ok) begin
                    out_data_d = sel_data;
                    state_d    = StOne;
                end
            end
            StOne: begin
                if (drain && acc_ok) begin
                    out_data_d = sel_data;
                end else if (drain) begin
                    // out_data keeps its last value when the stage empties.
                    state_d = StEmpty;
                end else if (acc_ok) begin
                    skid_data_d = sel_data;
                    state_d     = StFull;
                end
            end
            StFull: begin
                // in_ready is low here, so no accept can coincide.
                if (drain) begin
                    out_data_d = skid_data_q;
                    state_d    = StOne;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StEmpty;
            out_data_q  <= '0;
            skid_data_q <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
            sel_err_q   <= sel_err_d;
        end
    end

`ifdef MUX_N_REG_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = 8'd0;
        end else if (acc_bad && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed self-checking bench for mux_n_reg (N=3, WIDTH=32, SEL_W=2).
module tb_mux_n_reg;

    logic        clk;
    logic        reset_n;
    logic [95:0] in_data;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;
`ifdef MUX_N_REG_ERRCNT_EN
    logic [7:0]  err_count;
    logic        err_clr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mux_n_reg #(
        .WIDTH(32),
        .N    (3),
        .SEL_W(2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel_err  (sel_err)
`ifdef MUX_N_REG_ERRCNT_EN
        ,
        .err_count(err_count),
        .err_clr  (err_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] stream_exp [6];

    initial begin
        stream_exp[0] = 32'h11;
        stream_exp[1] = 32'h22;
        stream_exp[2] = 32'h33;
        stream_exp[3] = 32'h11;
        stream_exp[4] = 32'h22;
        stream_exp[5] = 32'h33;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 2'd0;
        in_data   = {32'h33, 32'h22, 32'h11};
`ifdef MUX_N_REG_ERRCNT_EN
        err_clr   = 1'b0;
`endif

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", out_data, 32'd0);
        check("rst_sel_err", 32'(sel_err), 32'd0);
`ifdef MUX_N_REG_ERRCNT_EN
        check("rst_err_count", 32'(err_count), 32'd0);
`endif
        reset_n = 1'b1;
        tick();

        // Single beat, latency 1
        sel       = 2'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("single_data", out_data, 32'h22);
        check("single_valid", 32'(out_valid), 32'd1);
        tick();
        check("single_drained", 32'(out_valid), 32'd0);
        check("single_hold_data", out_data, 32'h22);

        // Backpressure fills output then skid
        out_ready = 1'b0;
        sel       = 2'd0;
        in_valid  = 1'b1;
        tick();
        check("bp_first_data", out_data, 32'h11);
        check("bp_first_ready", 32'(in_ready), 32'd1);
        sel = 2'd2;
        tick();
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_full_data", out_data, 32'h11);
        check("bp_full_valid", 32'(out_valid), 32'd1);
        // Offered while not ready: must be ignored
        sel = 2'd1;
        tick();
        in_valid = 1'b0;
        check("bp_ignored_data", out_data, 32'h11);
        check("bp_ignored_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check("bp_skid_data", out_data, 32'h33);
        check("bp_skid_valid", 32'(out_valid), 32'd1);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Streaming at one beat per cycle
        for (int i = 0; i < 6; i++) begin
            sel      = 2'(i % 3);
            in_valid = 1'b1;
            tick();
            check("stream_data", out_data, stream_exp[i]);
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end", 32'(out_valid), 32'd0);

        // Invalid select
        sel      = 2'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bad_sel_err", 32'(sel_err), 32'd1);
        check("bad_no_valid", 32'(out_valid), 32'd0);
        tick();
        check("bad_err_pulse", 32'(sel_err), 32'd0);
        sel      = 2'd3;
        in_valid = 1'b1;
        tick();
        check("bad_b2b_1", 32'(sel_err), 32'd1);
        tick();
        check("bad_b2b_2", 32'(sel_err), 32'd1);
        check("bad_b2b_no_valid", 32'(out_valid), 32'd0);
        sel = 2'd0;
        tick();
        in_valid = 1'b0;
        check("after_bad_data", out_data, 32'h11);
        check("after_bad_valid", 32'(out_valid), 32'd1);
        check("after_bad_err", 32'(sel_err), 32'd0);
        tick();
        check("after_bad_drain", 32'(out_valid), 32'd0);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        sel       = 2'd1;
        in_valid  = 1'b1;
        tick();
        sel = 2'd2;
        tick();
        in_valid = 1'b0;
        check("prerst_full", 32'(in_ready), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_data", out_data, 32'd0);
        #2;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        tick();
        check("arst_no_beat_1", 32'(out_valid), 32'd0);
        tick();
        check("arst_no_beat_2", 32'(out_valid), 32'd0);

`ifdef MUX_N_REG_ERRCNT_EN
        // Saturating error counter and clear priority
        sel      = 2'd3;
        in_valid = 1'b1;
        repeat (300) tick();
        check("errcnt_sat", 32'(err_count), 32'd255);
        err_clr = 1'b1;
        tick();
        err_clr  = 1'b0;
        in_valid = 1'b0;
        check("errcnt_clr", 32'(err_count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
